// File: rtl/calc_pkg.sv
// Shared definitions for the RPN calculator keypad sequencer: key ids,
// sequencer states and the keypad digit decode.
package calc_pkg;

  localparam logic [3:0] KEY_1     = 4'h0;
  localparam logic [3:0] KEY_4     = 4'h1;
  localparam logic [3:0] KEY_7     = 4'h2;
  localparam logic [3:0] KEY_0     = 4'h3;
  localparam logic [3:0] KEY_2     = 4'h4;
  localparam logic [3:0] KEY_5     = 4'h5;
  localparam logic [3:0] KEY_8     = 4'h6;
  localparam logic [3:0] KEY_3     = 4'h8;
  localparam logic [3:0] KEY_6     = 4'h9;
  localparam logic [3:0] KEY_9     = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hC;
  localparam logic [3:0] KEY_ADD   = 4'hD;
  localparam logic [3:0] KEY_SUB   = 4'hE;
  localparam logic [3:0] KEY_MUL   = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    DISPATCH,
    MUL,
    COMMIT,
    RELEASE
  } seq_state_t;

  function automatic logic key_is_digit(input logic [3:0] id);
    case (id)
      KEY_0, KEY_1, KEY_2, KEY_3, KEY_4,
      KEY_5, KEY_6, KEY_7, KEY_8, KEY_9: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  // Ids are laid out by keypad column, so the digit value is not the id.
  function automatic logic [3:0] key_digit(input logic [3:0] id);
    case (id)
      KEY_1:   return 4'd1;
      KEY_2:   return 4'd2;
      KEY_3:   return 4'd3;
      KEY_4:   return 4'd4;
      KEY_5:   return 4'd5;
      KEY_6:   return 4'd6;
      KEY_7:   return 4'd7;
      KEY_8:   return 4'd8;
      KEY_9:   return 4'd9;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: WIDTH cycles per product, low WIDTH bits kept.
// done is high during the final iteration, with product already holding the result.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int ITER_W = $clog2(WIDTH);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(WIDTH - 1);

  logic [WIDTH-1:0]  mcand_reg;
  logic [WIDTH-1:0]  mplier_reg;
  logic [WIDTH-1:0]  acc_reg;
  logic [ITER_W-1:0] iter_reg;
  logic              running_reg;
  logic [WIDTH-1:0]  addend;

  assign addend  = mplier_reg[0] ? mcand_reg : '0;
  assign product = acc_reg + addend;
  assign done    = running_reg && (iter_reg == ITER_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      iter_reg    <= '0;
      running_reg <= 1'b0;
    end else if (clear) begin
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      iter_reg    <= '0;
      running_reg <= 1'b0;
    end else if (start) begin
      mcand_reg   <= multiplicand;
      mplier_reg  <= multiplier;
      acc_reg     <= '0;
      iter_reg    <= '0;
      running_reg <= 1'b1;
    end else if (running_reg) begin
      acc_reg    <= product;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      iter_reg   <= iter_reg + 1'b1;
      if (done) running_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Keypad-to-stack command sequencer: debounces key presses and issues one
// registered push/pop/write command per press, with an iterative multiply.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int WIDTH           = 32,
  parameter int COUNT_W         = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [4:0]         key,
  input  logic [WIDTH-1:0]   top,
  input  logic [WIDTH-1:0]   next,
  input  logic [COUNT_W-1:0] count,
  input  logic               stack_error,
  output logic               push,
  output logic               pop,
  output logic               write,
  output logic [WIDTH-1:0]   value,
  output logic               busy,
  output logic               op_error
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  seq_state_t       state_reg, state_next;
  logic [3:0]       code_reg, code_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             push_reg, push_next;
  logic             pop_reg, pop_next;
  logic             write_reg, write_next;
  logic             op_error_reg, op_error_next;
  logic             busy_reg;
  logic [WIDTH-1:0] value_reg, value_next;

  logic             mul_start;
  logic             mul_clear;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic             have_two;

  assign have_two = (count >= COUNT_W'(2));

  seq_multiplier #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clock       (clock),
    .reset       (reset),
    .clear       (mul_clear),
    .start       (mul_start),
    .multiplicand(next),
    .multiplier  (top),
    .done        (mul_done),
    .product     (mul_product)
  );

  always_comb begin
    state_next    = state_reg;
    code_next     = code_reg;
    cnt_next      = cnt_reg;
    push_next     = 1'b0;
    pop_next      = 1'b0;
    write_next    = 1'b0;
    op_error_next = 1'b0;
    value_next    = value_reg;
    mul_start     = 1'b0;
    mul_clear     = 1'b0;

    case (state_reg)
      IDLE: begin
        mul_clear = 1'b1;
        if (key[4]) begin
          code_next  = key[3:0];
          cnt_next   = '0;
          state_next = DEBOUNCE;
        end
      end

      DEBOUNCE: begin
        if (key != {1'b1, code_reg}) begin
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = DISPATCH;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      DISPATCH: begin
        state_next = RELEASE;
        cnt_next   = '0;
        if (!stack_error) begin
          if (key_is_digit(code_reg)) begin
            write_next = 1'b1;
            value_next = (top << 3) + (top << 1) + WIDTH'(key_digit(code_reg));
          end else begin
            case (code_reg)
              KEY_ENTER: push_next = 1'b1;
              KEY_ADD, KEY_SUB: begin
                if (have_two) begin
                  pop_next   = 1'b1;
                  write_next = 1'b1;
                  value_next = (code_reg == KEY_ADD) ? next + top : next - top;
                end else begin
                  op_error_next = 1'b1;
                end
              end
              KEY_MUL: begin
                if (have_two) begin
                  mul_start  = 1'b1;
                  state_next = MUL;
                end else begin
                  op_error_next = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end

      // Strobes are registered on the last iteration so they show during COMMIT.
      MUL: begin
        if (mul_done) begin
          pop_next   = 1'b1;
          write_next = 1'b1;
          value_next = mul_product;
          state_next = COMMIT;
        end
      end

      COMMIT: begin
        state_next = RELEASE;
        cnt_next   = '0;
      end

      RELEASE: begin
        if (key[4]) begin
          cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      code_reg     <= '0;
      cnt_reg      <= '0;
      push_reg     <= 1'b0;
      pop_reg      <= 1'b0;
      write_reg    <= 1'b0;
      op_error_reg <= 1'b0;
      busy_reg     <= 1'b0;
      value_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      code_reg     <= code_next;
      cnt_reg      <= cnt_next;
      push_reg     <= push_next;
      pop_reg      <= pop_next;
      write_reg    <= write_next;
      op_error_reg <= op_error_next;
      busy_reg     <= (state_next != IDLE);
      value_reg    <= value_next;
    end
  end

  assign push     = push_reg;
  assign pop      = pop_reg;
  assign write    = write_reg;
  assign op_error = op_error_reg;
  assign busy     = busy_reg;
  assign value    = value_reg;

endmodule
